// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit path.
// State encoding, bit-vote function and parameter range limits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int DIV_MIN   = 2;
    localparam int DIV_MAX   = 65535;
    localparam int OVS_MIN   = 8;
    localparam int OVS_MAX   = 32;
    localparam int DBITS_MIN = 5;
    localparam int DBITS_MAX = 9;

    function automatic logic majority3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: pulses tick every DIV clocks.
// restart realigns the phase to 0 (used at start-bit detect).
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit and parity_odd input.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DIV       = 27,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_div_bad
        $error("uart_rx_param: DIV out of range");
    end
    if (OVS < OVS_MIN || OVS > OVS_MAX || (OVS % 2) != 0) begin : g_ovs_bad
        $error("uart_rx_param: OVS illegal");
    end
    if (DATA_BITS < DBITS_MIN || DATA_BITS > DBITS_MAX) begin : g_db_bad
        $error("uart_rx_param: DATA_BITS out of range");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_sb_bad
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    localparam int TCW = $clog2(OVS);
    localparam logic [TCW-1:0] TC_V0  = TCW'(OVS / 2 - 1);
    localparam logic [TCW-1:0] TC_V1  = TCW'(OVS / 2);
    localparam logic [TCW-1:0] TC_RES = TCW'(OVS / 2 + 1);
    localparam logic [TCW-1:0] TC_END = TCW'(OVS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_armed;
    uart_rx_state_t       r_state;
    uart_rx_state_t       w_state_n;
    logic [TCW-1:0]       r_tc;
    logic [TCW-1:0]       w_tc_n;
    logic [3:0]           r_bc;
    logic [3:0]           w_bc_n;
    logic                 r_v0;
    logic                 r_v1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_parity_err;

    logic w_rxd_s;
    logic w_tick;
    logic w_restart;
    logic w_res;
    logic w_end;
    logic w_vote;
    logic w_shift;
    logic w_schk;
    logic w_done;

    assign w_rxd_s = r_sync2;
    assign w_res   = w_tick && (r_tc == TC_RES);
    assign w_end   = w_tick && (r_tc == TC_END);
    assign w_vote  = majority3(r_v0, r_v1, w_rxd_s);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(w_restart),
        .tick   (w_tick)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic w_pchk;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_tc    <= '0;
            r_bc    <= '0;
        end else begin
            r_state <= w_state_n;
            r_tc    <= w_tc_n;
            r_bc    <= w_bc_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_tc_n    = r_tc;
        w_bc_n    = r_bc;
        w_restart = 1'b0;
        w_shift   = 1'b0;
        w_schk    = 1'b0;
        w_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_pchk    = 1'b0;
`endif
        if (r_state != IDLE && w_tick) begin
            w_tc_n = (r_tc == TC_END) ? '0 : r_tc + 1'b1;
        end
        unique case (r_state)
            IDLE: begin
                if (r_armed && !w_rxd_s) begin
                    w_state_n = START;
                    w_tc_n    = '0;
                    w_restart = 1'b1;
                end
            end
            START: begin
                if (w_res && w_vote) begin
                    w_state_n = IDLE;
                end else if (w_end) begin
                    w_state_n = DATA;
                    w_bc_n    = '0;
                end
            end
            DATA: begin
                w_shift = w_res;
                if (w_end) begin
                    if (r_bc == 4'(DATA_BITS - 1)) begin
                        w_bc_n    = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_n = PARITY;
`else
                        w_state_n = STOP;
`endif
                    end else begin
                        w_bc_n = r_bc + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                w_pchk = w_res;
`endif
                if (w_end) begin
                    w_state_n = STOP;
                end
            end
            STOP: begin
                w_schk = w_res;
                // The last stop bit finishes at its vote, not its end
                if (w_res && r_bc == 4'(STOP_BITS - 1)) begin
                    w_done    = 1'b1;
                    w_state_n = IDLE;
                end else if (w_end) begin
                    w_bc_n = r_bc + 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_armed <= 1'b0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            if (w_tick && w_rxd_s) begin
                r_armed <= 1'b1;
            end
            if (w_tick && r_tc == TC_V0) begin
                r_v0 <= w_rxd_s;
            end
            if (w_tick && r_tc == TC_V1) begin
                r_v1 <= w_rxd_s;
            end
            if (w_restart) begin
                r_ferr <= 1'b0;
            end
            if (w_shift) begin
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            end
            if (w_schk && !w_vote) begin
                r_ferr <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (w_restart) begin
                r_par  <= 1'b0;
                r_perr <= 1'b0;
            end
            if (w_shift) begin
                r_par <= r_par ^ w_vote;
            end
            if (w_pchk) begin
                r_perr <= ((r_par ^ w_vote) != parity_odd);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out     <= '0;
            valid        <= 1'b0;
            frame_err    <= 1'b0;
            r_parity_err <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_done) begin
                if (!valid || ready) begin
                    data_out     <= r_shift;
                    valid        <= 1'b1;
                    frame_err    <= r_ferr | !w_vote;
`ifdef UART_RX_PARITY_EN
                    r_parity_err <= r_perr;
`else
                    r_parity_err <= 1'b0;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign parity_err = r_parity_err;

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the serial-link datapath. It oversamples an asynchronous `rxd` line using an internal baud tick and decodes frames of 5–9 data bits, LSB first, with 1 or 2 stop bits and optional parity. Each decoded word is presented on a valid/ready output register together with per-frame error status. It replaces the fixed 8N1 receiver and feeds the downstream protocol FIFO.

## Interface
- `DIV`, default 27: clk cycles per oversample tick; legal range 2..65535.
- `OVS`, default 16: oversample ticks per bit; must be even, legal range 8..32.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `rxd`, input, 1: asynchronous serial line; idles high.
- `parity_odd`, input, 1: 1 selects odd parity, 0 selects even. Present only with `UART_RX_PARITY_EN`.
- `data_out`, output, `DATA_BITS`: received word.
- `valid`, output, 1: `data_out` and the status bits are valid.
- `ready`, input, 1: consumer accepts the word.
- `frame_err`, output, 1: at least one stop bit sampled 0. Qualified by `valid`.
- `parity_err`, output, 1: parity mismatch. Qualified by `valid`. Tied 0 without the macro.
- `overrun`, output, 1: one-cycle pulse; a frame completed while `valid && !ready` and was dropped.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1) to produce `rxd_s`. All decisions use `rxd_s`.
- Tick generator counts 0..`DIV`-1 and pulses `tick` on wrap. It free-runs in IDLE and restarts at 0 on start detect.
- Arming: after reset, the receiver does not accept a start until `rxd_s`=1 has been seen on at least one tick. A line held low through reset never produces a frame.
- State encoding: IDLE, START, DATA, PARITY, STOP. The per-bit tick counter `tc` counts 0..`OVS`-1.
- IDLE: when armed and `rxd_s`=0, go to START with `tc`=0.
- Sampling: every bit is decided by majority vote over the ticks at `tc` = `OVS`/2-1, `OVS`/2 and `OVS`/2+1. The bit is resolved at `tc` = `OVS`/2+1 and the state advances when `tc` = `OVS`-1.
- START: if the vote is 1, it is a false start; return to IDLE immediately.
- DATA: shift in `DATA_BITS` bits, LSB first, using bit counter `bc`.
- PARITY: entered only with the macro. Compute the XOR of the data bits and the parity bit; a result ≠ `parity_odd` sets parity error.
- STOP: `STOP_BITS` bits. Any stop bit voting 0 sets frame error.
- Completion: at the last stop bit's resolve tick, return to IDLE. The receiver may detect a new start without waiting for the stop bit to end. The output register is loaded at the same time.
- Output register:
  - Load when `!valid || ready`: set `data_out` and the status bits, and assert `valid`.
  - Otherwise drop the new frame, hold the old contents, and pulse `overrun`.
- A frame with a framing error is still delivered, with `frame_err`=1.

## Timing
- Reset values: `data_out`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, state IDLE, unarmed.
- Start detect to the START resolve tick: `OVS`/2+2 ticks, including the synchronizer delay.
- `valid` rises 1 clk after the last stop bit's resolve tick.
- `valid` stays high until the clk edge where `ready`=1. A word is accepted on any cycle with `valid && ready`.
- `valid && ready` on the same cycle as a frame completes: the old word is accepted, the new word is loaded, `valid` stays 1, and no overrun occurs.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost.

## Configuration
- `UART_RX_PARITY_EN`, defined:
  - `parity_odd` port exists.
  - The PARITY state is inserted between DATA and STOP.
  - `parity_err` is live.
- Not defined:
  - No parity bit in the frame and no `parity_odd` port.
  - `parity_err` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - The state enum type `uart_rx_state_t`.
  - A `majority3` function.
  - Range-check constants for `DIV`, `OVS` and `DATA_BITS`.
- Sub-module `uart_baud_tick` is parameterised by `DIV` and has inputs `clk`, `rst`, `restart` and output `tick`. It is reused by the planned transmitter.

## Test plan
All scenarios use `DIV`=4, `OVS`=16, `DATA_BITS`=8, `STOP_BITS`=1.
- 8N1 frame of 0xA5 with `ready` held high: `valid` pulses for 1 clk with `data_out`=0xA5 and both error bits 0.
- Glitch low on `rxd` for 20 clk (< `OVS`/2 ticks): no `valid`, state returns to IDLE.
- Frame 0x3C with stop bit 0: `data_out`=0x3C, `frame_err`=1.
- With the macro, even parity, frame 0x07 with parity bit 0: `parity_err`=1. The same frame with parity bit 1 gives `parity_err`=0.
- Frames 0x11 then 0x22 with `ready`=0: `data_out` holds 0x11 and `overrun` pulses once. Raising `ready` on the completion cycle of 0x22 instead loads 0x22 with no overrun.
- `rst` low during bit 4 of a frame: all outputs 0. With `rxd` held low across reset release, no frame is produced until `rxd` returns high.
